// File: rtl/hazard_control_pkg.sv
// hazard_control_pkg
// Shared definitions for the pipeline hazard controller:
//   - 7-bit opcode constants (instruction bits 31:25)
//   - operand forwarding select encodings driven on fwd_a / fwd_b
//   - controller FSM state enum
//   - per-stage scoreboard entry layout and the producer-match helper
package hazard_control_pkg;

  localparam logic [6:0] OP_ADD  = 7'h00;
  localparam logic [6:0] OP_SUB  = 7'h01;
  localparam logic [6:0] OP_MUL  = 7'h02;
  localparam logic [6:0] OP_LDB  = 7'h10;
  localparam logic [6:0] OP_LDW  = 7'h11;
  localparam logic [6:0] OP_STB  = 7'h12;
  localparam logic [6:0] OP_STW  = 7'h13;
  localparam logic [6:0] OP_MOV  = 7'h14;
  localparam logic [6:0] OP_BEQ  = 7'h30;
  localparam logic [6:0] OP_JUMP = 7'h31;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_M  = 2'b01;
  localparam logic [1:0] FWD_W  = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MUL_BUSY = 2'd1,
    ST_MEM_WAIT = 2'd2
  } hc_state_t;

  // writes_rd is captured already qualified with rd != r0, so an entry
  // targeting r0 can never match as a producer.
  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       is_load;
    logic       writes_rd;
  } sb_entry_t;

  function automatic logic produces(input sb_entry_t e, input logic [4:0] src);
    return e.valid && e.writes_rd && (e.rd == src);
  endfunction

endpackage

// File: rtl/hazard_control_op_class.sv
// op_class
// Decodes a D-stage opcode into the attributes the hazard logic needs.
// Ports:
//   op        in  7  opcode (instruction bits 31:25)
//   writes_rd out 1  instruction writes its rd field
//   reads_a   out 1  instruction reads ra
//   reads_b   out 1  instruction reads rb
//   is_load   out 1  LDB / LDW
//   is_mul    out 1  MUL (multi-cycle in E)
module op_class
  import hazard_control_pkg::*;
(
  input  logic [6:0] op,
  output logic       writes_rd,
  output logic       reads_a,
  output logic       reads_b,
  output logic       is_load,
  output logic       is_mul
);

  // Unknown opcodes fall through the defaults: they read ra and nothing else.
  always_comb begin
    writes_rd = 1'b0;
    reads_a   = 1'b1;
    reads_b   = 1'b0;
    is_load   = 1'b0;
    is_mul    = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        writes_rd = 1'b1;
        reads_b   = 1'b1;
      end
      OP_MUL: begin
        writes_rd = 1'b1;
        reads_b   = 1'b1;
        is_mul    = 1'b1;
      end
      OP_LDB, OP_LDW: begin
        writes_rd = 1'b1;
        is_load   = 1'b1;
      end
      OP_MOV: writes_rd = 1'b1;
      OP_STB, OP_STW, OP_BEQ: reads_b = 1'b1;
      OP_JUMP: reads_a = 1'b0;
      default: ;
    endcase
  end

endmodule

// File: rtl/hazard_control.sv
// hazard_control
// Pipeline hazard controller for a 5-stage F/D/E/M/W pipeline. Tracks the
// destination of the instructions in E, M and W, selects operand forwarding
// for the D-stage instruction, and generates stall / hold / bubble / flush
// controls for load-use, multi-cycle MUL, data cache miss and taken branch.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   d_valid, d_op              D-stage valid and opcode
//   d_addr_d/_a/_b             D-stage rd, ra, rb
//   branch_taken               E resolves a taken branch/jump
//   mem_busy                   M waits on a data cache miss
//   stall_fd, flush_fd         hold / invalidate F and D
//   hold_e, hold_m             hold E / M registers
//   bubble_e, bubble_m, bubble_w  load NOP into E / M / W
//   fwd_a, fwd_b               operand source (RF / M / W)
module hazard_control
  import hazard_control_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       d_valid,
  input  logic [6:0] d_op,
  input  logic [4:0] d_addr_d,
  input  logic [4:0] d_addr_a,
  input  logic [4:0] d_addr_b,
  input  logic       branch_taken,
  input  logic       mem_busy,
  output logic       stall_fd,
  output logic       hold_e,
  output logic       hold_m,
  output logic       bubble_e,
  output logic       bubble_m,
  output logic       bubble_w,
  output logic       flush_fd,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  // The cycle a MUL enters E counts as its first, so the counter holds the
  // number of further cycles E must be held.
  localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

  logic       d_writes_rd;
  logic       d_reads_a;
  logic       d_reads_b;
  logic       d_is_load;
  logic       d_is_mul;

  sb_entry_t  d_entry;
  sb_entry_t  sb_e;
  sb_entry_t  sb_m;
  sb_entry_t  sb_w;

  hc_state_t  state;
  hc_state_t  state_nx;
  hc_state_t  ret_state;
  hc_state_t  ret_nx;
  logic [3:0] mul_cnt;
  logic [3:0] mul_cnt_nx;

  logic       mul_busy;
  logic       load_use;
  logic       mul_enter;

  op_class u_op_class (
    .op        (d_op),
    .writes_rd (d_writes_rd),
    .reads_a   (d_reads_a),
    .reads_b   (d_reads_b),
    .is_load   (d_is_load),
    .is_mul    (d_is_mul)
  );

  assign d_entry  = {d_valid, d_addr_d, d_is_load, d_writes_rd && (d_addr_d != 5'd0)};
  assign mul_busy = (mul_cnt != 4'd0);

  assign load_use = d_valid && sb_e.valid && sb_e.is_load && sb_e.writes_rd &&
                    ((d_reads_a && (d_addr_a == sb_e.rd)) ||
                     (d_reads_b && (d_addr_b == sb_e.rd)));

  // Control outputs, highest priority first: cache miss, taken branch,
  // busy MUL, load-use. A branch squashes the D instruction, so any
  // load-use stall it would have caused is moot.
  always_comb begin
    stall_fd = 1'b0;
    hold_e   = 1'b0;
    hold_m   = 1'b0;
    bubble_e = 1'b0;
    bubble_m = 1'b0;
    bubble_w = 1'b0;
    flush_fd = 1'b0;
    if (rst_n) begin
      if (mem_busy) begin
        stall_fd = 1'b1;
        hold_e   = 1'b1;
        hold_m   = 1'b1;
        bubble_w = 1'b1;
      end else if (branch_taken) begin
        flush_fd = 1'b1;
        bubble_e = 1'b1;
      end else if (mul_busy) begin
        stall_fd = 1'b1;
        hold_e   = 1'b1;
        bubble_m = 1'b1;
      end else if (load_use) begin
        stall_fd = 1'b1;
        bubble_e = 1'b1;
      end
    end
  end

  // Forwarding prefers the younger producer in M over W.
  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (rst_n && d_valid) begin
      if (produces(sb_m, d_addr_a))      fwd_a = FWD_M;
      else if (produces(sb_w, d_addr_a)) fwd_a = FWD_W;
      if (produces(sb_m, d_addr_b))      fwd_b = FWD_M;
      else if (produces(sb_w, d_addr_b)) fwd_b = FWD_W;
    end
  end

  assign mul_enter = d_valid && d_is_mul && !hold_e && !bubble_e;

  // MEM_WAIT remembers the state it interrupted and freezes the MUL counter.
  // On exit the interrupted state resumes this very cycle, so the counter
  // and the MUL-done check proceed as if no miss had occurred. A branch
  // bubbles E, which abandons any MUL still there.
  always_comb begin
    state_nx   = state;
    ret_nx     = ret_state;
    mul_cnt_nx = mul_cnt;
    if (mem_busy) begin
      state_nx = ST_MEM_WAIT;
      if (state != ST_MEM_WAIT) ret_nx = state;
    end else begin
      state_nx = (state == ST_MEM_WAIT) ? ret_state : state;
      if (branch_taken) begin
        mul_cnt_nx = 4'd0;
        state_nx   = ST_RUN;
      end else if (mul_busy) begin
        mul_cnt_nx = mul_cnt - 4'd1;
        if (mul_cnt == 4'd1) state_nx = ST_RUN;
      end else if (mul_enter) begin
        mul_cnt_nx = MUL_LOAD;
        state_nx   = ST_MUL_BUSY;
      end
    end
  end

  // FSM and MUL counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RUN;
      ret_state <= ST_RUN;
      mul_cnt   <= 4'd0;
    end else begin
      state     <= state_nx;
      ret_state <= ret_nx;
      mul_cnt   <= mul_cnt_nx;
    end
  end

  // Scoreboard entries move with the pipeline registers they shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_e <= '0;
      sb_m <= '0;
      sb_w <= '0;
    end else begin
      sb_w <= bubble_w ? '0 : sb_m;
      if (!hold_m) sb_m <= bubble_m ? '0 : sb_e;
      if (!hold_e) sb_e <= bubble_e ? '0 : d_entry;
    end
  end

endmodule

// File: tb/tb_hazard_control.sv
// tb_hazard_control
// Self-checking bench for hazard_control: directed cycle tables for the
// forwarding / load-use / MUL / cache-miss / branch scenarios, a reset
// sequence abandoning a MUL inside a cache miss, and randomized traffic
// compared against an instruction-level pipeline model.
module tb_hazard_control;
  import hazard_control_pkg::*;

  localparam int MC = 5;

  // Output vector layout: {stall_fd, hold_e, hold_m, bubble_e, bubble_m,
  // bubble_w, flush_fd, fwd_a[1:0], fwd_b[1:0]}
  localparam logic [10:0] O_STALL = 11'h400;
  localparam logic [10:0] O_HOLDE = 11'h200;
  localparam logic [10:0] O_HOLDM = 11'h100;
  localparam logic [10:0] O_BUBE  = 11'h080;
  localparam logic [10:0] O_BUBM  = 11'h040;
  localparam logic [10:0] O_BUBW  = 11'h020;
  localparam logic [10:0] O_FLUSH = 11'h010;
  localparam logic [10:0] FA_M    = 11'h004;
  localparam logic [10:0] FA_W    = 11'h008;
  localparam logic [10:0] FB_M    = 11'h001;
  localparam logic [10:0] FB_W    = 11'h002;
  localparam logic [10:0] LU      = O_STALL | O_BUBE;
  localparam logic [10:0] MULB    = O_STALL | O_HOLDE | O_BUBM;
  localparam logic [10:0] MEMW    = O_STALL | O_HOLDE | O_HOLDM | O_BUBW;
  localparam logic [10:0] BR      = O_FLUSH | O_BUBE;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       d_valid = 1'b0;
  logic [6:0] d_op = 7'h00;
  logic [4:0] d_addr_d = 5'd0;
  logic [4:0] d_addr_a = 5'd0;
  logic [4:0] d_addr_b = 5'd0;
  logic       branch_taken = 1'b0;
  logic       mem_busy = 1'b0;
  logic       stall_fd, hold_e, hold_m, bubble_e, bubble_m, bubble_w, flush_fd;
  logic [1:0] fwd_a, fwd_b;

  always #5 clk = ~clk;

  hazard_control #(.MUL_CYCLES(MC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .d_valid      (d_valid),
    .d_op         (d_op),
    .d_addr_d     (d_addr_d),
    .d_addr_a     (d_addr_a),
    .d_addr_b     (d_addr_b),
    .branch_taken (branch_taken),
    .mem_busy     (mem_busy),
    .stall_fd     (stall_fd),
    .hold_e       (hold_e),
    .hold_m       (hold_m),
    .bubble_e     (bubble_e),
    .bubble_m     (bubble_m),
    .bubble_w     (bubble_w),
    .flush_fd     (flush_fd),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b)
  );

  typedef struct {
    logic        rst_n;
    logic        dv;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic        br;
    logic        mb;
    logic [10:0] exp;
  } vec_t;

  typedef struct {
    logic       v;
    logic [6:0] op;
    logic [4:0] rd;
  } minst_t;

  int checks = 0;
  int errors = 0;

  vec_t   tbl[$];
  vec_t   rs;
  minst_t m_e, m_m, m_w;
  int     e_age;
  int     mem_run;
  logic [6:0] op_pool [11];

  function automatic vec_t row(input logic dv, input logic [6:0] op,
                               input logic [4:0] rd, input logic [4:0] ra,
                               input logic [4:0] rb, input logic br,
                               input logic mb, input logic [10:0] ex);
    vec_t v;
    v.rst_n = 1'b1;
    v.dv = dv; v.op = op; v.rd = rd; v.ra = ra; v.rb = rb;
    v.br = br; v.mb = mb; v.exp = ex;
    return v;
  endfunction

  function automatic logic [10:0] dut_out();
    return {stall_fd, hold_e, hold_m, bubble_e, bubble_m, bubble_w, flush_fd, fwd_a, fwd_b};
  endfunction

  task automatic applyStimulus(input vec_t v);
    @(posedge clk);
    #1;
    rst_n        = v.rst_n;
    d_valid      = v.dv;
    d_op         = v.op;
    d_addr_d     = v.rd;
    d_addr_a     = v.ra;
    d_addr_b     = v.rb;
    branch_taken = v.br;
    mem_busy     = v.mb;
  endtask

  task automatic checkOutput(input string name, input logic [10:0] expv);
    @(negedge clk);
    checks++;
    if (dut_out() !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b", name, dut_out(), expv);
    end
  endtask

  // Reference model: the instructions sitting in E, M, W and how long the
  // E instruction has spent there; rules stated at the instruction level.
  function automatic logic m_writes(input logic [6:0] op);
    return op inside {OP_ADD, OP_SUB, OP_MUL, OP_LDB, OP_LDW, OP_MOV};
  endfunction

  function automatic logic m_reads_a(input logic [6:0] op);
    return op != OP_JUMP;
  endfunction

  function automatic logic m_reads_b(input logic [6:0] op);
    return op inside {OP_ADD, OP_SUB, OP_MUL, OP_STB, OP_STW, OP_BEQ};
  endfunction

  function automatic logic m_prod(input minst_t i, input logic [4:0] r);
    return i.v && m_writes(i.op) && (i.rd == r) && (r != 5'd0);
  endfunction

  function automatic logic [10:0] model_exp(input vec_t s);
    logic [10:0] o;
    logic        lu, busy;
    o = '0;
    if (!s.rst_n) return o;
    if (s.dv) begin
      if (m_prod(m_m, s.ra))      o |= FA_M;
      else if (m_prod(m_w, s.ra)) o |= FA_W;
      if (m_prod(m_m, s.rb))      o |= FB_M;
      else if (m_prod(m_w, s.rb)) o |= FB_W;
    end
    lu = s.dv && m_e.v && (m_e.op inside {OP_LDB, OP_LDW}) && (m_e.rd != 5'd0) &&
         ((m_reads_a(s.op) && s.ra == m_e.rd) || (m_reads_b(s.op) && s.rb == m_e.rd));
    busy = m_e.v && (m_e.op == OP_MUL) && (e_age < MC);
    if (s.mb)      o |= MEMW;
    else if (s.br) o |= BR;
    else if (busy) o |= MULB;
    else if (lu)   o |= LU;
    return o;
  endfunction

  task automatic model_advance(input vec_t s);
    minst_t nop;
    nop = '{v: 1'b0, op: 7'h00, rd: 5'd0};
    if (!s.rst_n) begin
      m_e = nop; m_m = nop; m_w = nop; e_age = 0;
      return;
    end
    m_w = (s.exp & O_BUBW) != 0 ? nop : m_m;
    if ((s.exp & O_HOLDM) == 0) m_m = (s.exp & O_BUBM) != 0 ? nop : m_e;
    if ((s.exp & O_HOLDE) != 0) begin
      if (!s.mb) e_age++;
    end else if ((s.exp & O_BUBE) != 0) begin
      m_e = nop; e_age = 0;
    end else begin
      m_e = '{v: s.dv, op: s.op, rd: s.rd};
      e_age = 1;
    end
  endtask

  initial begin
    // Reset: outputs stay low even with every request input active.
    rs = row(1, OP_MUL, 5'd1, 5'd1, 5'd1, 1, 1, 11'h000);
    rs.rst_n = 1'b0;
    applyStimulus(rs);
    checkOutput("reset_outputs", 11'h000);
    applyStimulus(row(0, OP_ADD, 5'd0, 5'd0, 5'd0, 0, 0, 11'h000));
    checkOutput("reset_release", 11'h000);

    // Directed pipeline walk, one row per cycle.
    tbl.push_back(row(1, OP_ADD,  5'd3, 5'd1, 5'd2, 0, 0, 11'h000));
    tbl.push_back(row(1, OP_ADD,  5'd0, 5'd1, 5'd1, 0, 0, 11'h000));
    tbl.push_back(row(1, OP_SUB,  5'd4, 5'd3, 5'd0, 0, 0, FA_M));
    tbl.push_back(row(1, OP_ADD,  5'd7, 5'd0, 5'd3, 0, 0, FB_W));
    tbl.push_back(row(1, OP_LDW,  5'd5, 5'd1, 5'd2, 0, 0, 11'h000));
    tbl.push_back(row(1, OP_ADD,  5'd6, 5'd1, 5'd5, 0, 0, LU));
    tbl.push_back(row(1, OP_ADD,  5'd6, 5'd1, 5'd5, 0, 0, FB_M));
    tbl.push_back(row(1, OP_MUL,  5'd2, 5'd1, 5'd1, 0, 0, 11'h000));
    for (int i = 0; i < 4; i++)
      tbl.push_back(row(1, OP_ADD, 5'd1, 5'd2, 5'd2, 0, 0, MULB));
    tbl.push_back(row(1, OP_ADD,  5'd1, 5'd2, 5'd2, 0, 0, 11'h000));
    tbl.push_back(row(0, OP_ADD,  5'd1, 5'd2, 5'd2, 0, 0, 11'h000));
    tbl.push_back(row(1, OP_MUL,  5'd3, 5'd0, 5'd0, 0, 0, 11'h000));
    tbl.push_back(row(1, OP_ADD,  5'd4, 5'd1, 5'd1, 0, 0, MULB | FA_W | FB_W));
    for (int i = 0; i < 3; i++)
      tbl.push_back(row(1, OP_ADD, 5'd4, 5'd1, 5'd1, 0, 1, MEMW));
    for (int i = 0; i < 3; i++)
      tbl.push_back(row(1, OP_ADD, 5'd4, 5'd1, 5'd1, 0, 0, MULB));
    tbl.push_back(row(1, OP_ADD,  5'd4, 5'd1, 5'd1, 0, 0, 11'h000));
    tbl.push_back(row(1, OP_LDB,  5'd2, 5'd1, 5'd0, 0, 0, 11'h000));
    tbl.push_back(row(1, OP_STW,  5'd0, 5'd2, 5'd4, 1, 0, BR | FB_M));
    tbl.push_back(row(1, OP_LDW,  5'd6, 5'd1, 5'd1, 0, 0, 11'h000));
    tbl.push_back(row(1, OP_JUMP, 5'd0, 5'd6, 5'd6, 0, 0, 11'h000));
    tbl.push_back(row(1, OP_STB,  5'd0, 5'd1, 5'd6, 0, 0, FB_M));
    tbl.push_back(row(1, OP_MOV,  5'd1, 5'd6, 5'd1, 1, 1, MEMW | FA_W));
    tbl.push_back(row(1, OP_MOV,  5'd1, 5'd6, 5'd1, 0, 0, 11'h000));
    foreach (tbl[i]) begin
      applyStimulus(tbl[i]);
      checkOutput($sformatf("dir%0d", i + 1), tbl[i].exp);
    end

    // Reset asserted inside a cache miss that interrupted a MUL.
    rs = row(0, OP_ADD, 5'd0, 5'd0, 5'd0, 0, 0, 11'h000);
    rs.rst_n = 1'b0;
    applyStimulus(rs);
    checkOutput("rst2_outputs", 11'h000);
    applyStimulus(row(1, OP_MUL, 5'd1, 5'd0, 5'd0, 0, 0, 11'h000));
    checkOutput("mul_enter", 11'h000);
    applyStimulus(row(0, OP_ADD, 5'd0, 5'd0, 5'd0, 0, 0, 11'h000));
    checkOutput("mul_busy", MULB);
    applyStimulus(row(0, OP_ADD, 5'd0, 5'd0, 5'd0, 0, 1, 11'h000));
    checkOutput("mem_wait", MEMW);
    rs = row(1, OP_LDW, 5'd1, 5'd1, 5'd1, 1, 1, 11'h000);
    rs.rst_n = 1'b0;
    applyStimulus(rs);
    checkOutput("rst_mid_wait", 11'h000);
    applyStimulus(row(0, OP_ADD, 5'd0, 5'd0, 5'd0, 0, 0, 11'h000));
    checkOutput("clean_run1", 11'h000);
    applyStimulus(row(1, OP_ADD, 5'd2, 5'd1, 5'd1, 0, 0, 11'h000));
    checkOutput("clean_run2", 11'h000);

    // Randomized traffic against the reference model.
    op_pool = '{OP_ADD, OP_SUB, OP_MUL, OP_LDB, OP_LDW, OP_STB, OP_STW,
                OP_MOV, OP_BEQ, OP_JUMP, 7'h7F};
    mem_run = 0;
    for (int i = 0; i < 3000; i++) begin
      rs.rst_n = (i == 0) ? 1'b0 : ($urandom_range(0, 299) != 0);
      rs.dv    = ($urandom_range(0, 99) < 85);
      rs.op    = op_pool[$urandom_range(0, 10)];
      rs.rd    = 5'($urandom_range(0, 3));
      rs.ra    = 5'($urandom_range(0, 3));
      rs.rb    = 5'($urandom_range(0, 3));
      rs.br    = ($urandom_range(0, 99) < 8);
      if (mem_run == 0 && $urandom_range(0, 99) < 8) mem_run = $urandom_range(1, 4);
      rs.mb = (mem_run != 0);
      if (mem_run != 0) mem_run--;
      rs.exp = model_exp(rs);
      applyStimulus(rs);
      checkOutput($sformatf("rand%0d", i), rs.exp);
      model_advance(rs);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
